// File: rtl/udiv_pkg.sv
// Shared constants and types for the unsigned sequential divider.
package udiv_pkg;

  localparam int unsigned DIV_WIDTH = 24;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Bits needed to hold a count of value-1 down to 0 (never less than 1).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(value)) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/udiv_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference when it does not borrow.
module udiv_step
  import udiv_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   r,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   r_next,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+2:0] diff;

  // Trial subtraction with an extra sign bit so the borrow is explicit.
  always_comb begin
    shifted = {r, bit_in};
    diff    = {1'b0, shifted} - (WIDTH+3)'(divisor);
    q_bit   = ~diff[WIDTH+2];
    r_next  = q_bit ? (WIDTH+1)'(diff) : (WIDTH+1)'(shifted);
  end

endmodule

// File: rtl/unsig_seq_divider.sv
// Unsigned radix-2 restoring divider: 2W-bit dividend / W-bit divisor,
// one quotient bit per clock, start/valid handshake.
module unsig_seq_divider
  import udiv_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [2*WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0]   divisor_i,
  output logic               ready_o,
  output logic               valid_o,
  output logic [WIDTH-1:0]   quotient_o,
  output logic [WIDTH-1:0]   remainder_o,
  output logic               dz_o,
  output logic               ovf_o
);

  localparam int unsigned CW = clog2(WIDTH);

  state_t             state_q;
  state_t             state_d;
  logic [2*WIDTH-1:0] dividend_q;
  logic [WIDTH-1:0]   divisor_q;
  logic [WIDTH:0]     r_q;
  logic [WIDTH-1:0]   q_q;
  logic [CW-1:0]      cnt_q;
  logic               exc_q;
  logic [WIDTH:0]     r_step;
  logic               q_bit;

  udiv_step #(.WIDTH(WIDTH)) u_step (
    .r       (r_q),
    .bit_in  (q_q[WIDTH-1]),
    .divisor (divisor_q),
    .r_next  (r_step),
    .q_bit   (q_bit)
  );

  // State register plus registered handshake outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_o <= (state_d == S_IDLE);
      valid_o <= (state_d == S_DONE);
    end
  end

  // Next-state logic. Exceptions spend one idle RUN slot so their result
  // arrives a fixed two clocks after the accepting edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_CHECK;
      S_CHECK: state_d = S_RUN;
      S_RUN:   if (exc_q || cnt_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand latch, exception check, iteration registers and result capture.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dividend_q  <= '0;
      divisor_q   <= '0;
      r_q         <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      exc_q       <= 1'b0;
      dz_o        <= 1'b0;
      ovf_o       <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            dividend_q <= dividend_i;
            divisor_q  <= divisor_i;
            dz_o       <= 1'b0;
            ovf_o      <= 1'b0;
            exc_q      <= 1'b0;
          end
        end
        S_CHECK: begin
          cnt_q <= CW'(WIDTH - 1);
          if (divisor_q == '0) begin
            q_q   <= '1;
            r_q   <= {1'b0, dividend_q[WIDTH-1:0]};
            dz_o  <= 1'b1;
            exc_q <= 1'b1;
          end else if (dividend_q[2*WIDTH-1:WIDTH] >= divisor_q) begin
            q_q   <= '1;
            r_q   <= '0;
            ovf_o <= 1'b1;
            exc_q <= 1'b1;
          end else begin
            r_q <= {1'b0, dividend_q[2*WIDTH-1:WIDTH]};
            q_q <= dividend_q[WIDTH-1:0];
          end
        end
        S_RUN: begin
          if (!exc_q) begin
            r_q <= r_step;
            q_q <= WIDTH'({q_q, q_bit});
            if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
          end
          if (exc_q) begin
            quotient_o  <= q_q;
            remainder_o <= WIDTH'(r_q);
          end else if (cnt_q == '0) begin
            quotient_o  <= WIDTH'({q_q, q_bit});
            remainder_o <= WIDTH'(r_step);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unsig_seq_divider.sv
// Self-checking bench for unsig_seq_divider: vector table, scoreboard,
// handshake and reset corner cases, random multiply/divide round trips.
module tb_unsig_seq_divider;

  localparam int unsigned W = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2*W-1:0] dividend;
  logic [W-1:0]  divisor;
  logic          ready;
  logic          valid;
  logic [W-1:0]  quotient;
  logic [W-1:0]  remainder;
  logic          dz;
  logic          ovf;

  unsig_seq_divider #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .dividend_i  (dividend),
    .divisor_i   (divisor),
    .ready_o     (ready),
    .valid_o     (valid),
    .quotient_o  (quotient),
    .remainder_o (remainder),
    .dz_o        (dz),
    .ovf_o       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ovf;
  } res_t;

  typedef struct {
    logic [2*W-1:0] dd;
    logic [W-1:0]   dv;
    res_t           exp;
    int             lat;
  } vec_t;

  res_t sbq[$];
  res_t mon_e;
  vec_t tbl[11];
  int   checks = 0;
  int   passes = 0;
  int   valid_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard: every valid pulse pops and compares the oldest expectation.
  always @(negedge clk) begin
    if (valid) valid_cnt++;
    if (!rst && valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_valid", 64'(valid), 64'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("quotient", 64'(quotient), 64'(mon_e.q));
        chk("remainder", 64'(remainder), 64'(mon_e.r));
        chk("dz", 64'(dz), 64'(mon_e.dz));
        chk("ovf", 64'(ovf), 64'(mon_e.ovf));
      end
    end
  end

  // Issue one operation and check latency, pulse width and result hold.
  // A nonzero glitch pulses start with junk operands on that busy cycle.
  task automatic issue(input logic [2*W-1:0] dd, input logic [W-1:0] dv,
                       input res_t exp, input int exp_lat, input int glitch);
    int k;
    int lat;
    k = 0;
    @(negedge clk);
    while (!ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("ready_wait", 64'(ready), 64'd1);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    sbq.push_back(exp);
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = {16'($urandom), 32'($urandom)};
    divisor  = 24'($urandom);
    chk("ready_low_busy", 64'(ready), 64'd0);
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      if (c == glitch) begin
        start    = 1'b1;
        dividend = 48'h0000_1234_5678;
        divisor  = 24'h000003;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (valid) begin
        lat = c;
        break;
      end
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    @(posedge clk);
    #1;
    chk("valid_pulse", 64'(valid), 64'd0);
    chk("ready_back", 64'(ready), 64'd1);
    chk("quotient_hold", 64'(quotient), 64'(exp.q));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] prod;
    int             v0;
    res_t           e;

    tbl[0]  = '{48'd100,            24'd7,       '{24'd14,     24'd2,      1'b0, 1'b0}, 25};
    tbl[1]  = '{48'h7FFFFF_FFFFFF,  24'h800000,  '{24'hFFFFFF, 24'h7FFFFF, 1'b0, 1'b0}, 25};
    tbl[2]  = '{48'h000000_001234,  24'h000000,  '{24'hFFFFFF, 24'h001234, 1'b1, 1'b0}, 2};
    tbl[3]  = '{48'h000010_000000,  24'h000010,  '{24'hFFFFFF, 24'h000000, 1'b0, 1'b1}, 2};
    tbl[4]  = '{48'd0,              24'd5,       '{24'd0,      24'd0,      1'b0, 1'b0}, 25};
    tbl[5]  = '{48'd1000,           24'd1000,    '{24'd1,      24'd0,      1'b0, 1'b0}, 25};
    tbl[6]  = '{48'h000001_000000,  24'd2,       '{24'h800000, 24'd0,      1'b0, 1'b0}, 25};
    tbl[7]  = '{48'h000000_ABCDEF,  24'd1,       '{24'hABCDEF, 24'd0,      1'b0, 1'b0}, 25};
    tbl[8]  = '{48'h000005_000000,  24'd5,       '{24'hFFFFFF, 24'd0,      1'b0, 1'b1}, 2};
    tbl[9]  = '{48'hFFFFFF_00ABCD,  24'd0,       '{24'hFFFFFF, 24'h00ABCD, 1'b1, 1'b0}, 2};
    tbl[10] = '{48'h000004_000003,  24'd5,       '{24'hCCCCCD, 24'd2,      1'b0, 1'b0}, 25};

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_quotient", 64'(quotient), 64'd0);
    chk("rst_remainder", 64'(remainder), 64'd0);
    chk("rst_dz", 64'(dz), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    rst = 1'b0;

    // Directed vectors, back to back.
    for (int i = 0; i < 11; i++)
      issue(tbl[i].dd, tbl[i].dv, tbl[i].exp, tbl[i].lat, 0);

    // Start pulsed while busy must be ignored.
    issue(48'd100, 24'd7, '{24'd14, 24'd2, 1'b0, 1'b0}, 25, 5);

    // Reset ten cycles into an operation aborts it without a valid pulse.
    @(negedge clk);
    dividend = 48'h000003_123456;
    divisor  = 24'h00F00D;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_ready", 64'(ready), 64'd1);
    chk("abort_valid", 64'(valid), 64'd0);
    chk("abort_quotient", 64'(quotient), 64'd0);
    chk("abort_remainder", 64'(remainder), 64'd0);
    chk("abort_dz", 64'(dz), 64'd0);
    chk("abort_ovf", 64'(ovf), 64'd0);
    v0 = valid_cnt;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_no_valid", 64'(valid_cnt - v0), 64'd0);

    // Round trip: (a*b)/b must give a with zero remainder.
    for (int n = 0; n < 1000; n++) begin
      a = 24'($urandom);
      b = 24'($urandom);
      if (b == '0) b = 24'd1;
      prod = 48'(a) * 48'(b);
      e = '{a, 24'd0, 1'b0, 1'b0};
      issue(prod, b, e, 25, 0);
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
